// File: rtl/color_msg_uart_tx.sv
// rtl/color_msg_uart_tx.sv - framed colour-code packet transmitter over UART
//
// Sends one 6-byte packet 'S','I','-',MSG,'-','#' per rising edge of done,
// 8N1 framing, LSB first. Optional macro UART_PARITY_EN inserts an even
// parity bit between the data bits and the stop bit (8E1).
//
// Ports:
//   clk50    in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   done     in   detection-valid level from the colour stage
//   message  in   ASCII colour code ('D','M','W' legal), valid while done=1
//   tx       out  UART serial line, idles high, registered
//   busy     out  high from start bit of byte 0 until stop bit of byte 5 ends
//   sent     out  one-cycle pulse on packet completion
//   bad_code out  one-cycle pulse when a done edge carries an illegal code
module color_msg_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       done,
  input  logic [7:0] message,
  output logic       tx,
  output logic       busy,
  output logic       sent,
  output logic       bad_code
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [2:0]       byte_idx, byte_idx_n;
  logic [7:0]       msg_q, msg_q_n;
  logic [7:0]       cur_byte;
  logic             done_q;
  logic             tx_q, tx_n;
  logic             sent_q, sent_n;
  logic             bad_q, bad_n;
  logic             trigger;
  logic             code_ok;
  logic             baud_last;

  assign trigger   = done && !done_q;
  assign code_ok   = (message == 8'h44) || (message == 8'h4D) || (message == 8'h57);
  assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = 8'h53;
      3'd1:    cur_byte = 8'h49;
      3'd2:    cur_byte = 8'h2D;
      3'd3:    cur_byte = msg_q;
      3'd4:    cur_byte = 8'h2D;
      default: cur_byte = 8'h23;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      msg_q    <= 8'h00;
      done_q   <= 1'b0;
      tx_q     <= 1'b1;
      sent_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      msg_q    <= msg_q_n;
      done_q   <= done;
      tx_q     <= tx_n;
      sent_q   <= sent_n;
      bad_q    <= bad_n;
    end
  end

  // tx_n is the line level for the cycle after this edge, so every
  // transition computes the level of the bit it is entering.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    msg_q_n    = msg_q;
    tx_n       = tx_q;
    sent_n     = 1'b0;
    bad_n      = 1'b0;

    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        if (trigger) begin
          if (code_ok) begin
            msg_q_n    = message;
            byte_idx_n = 3'd0;
            bit_idx_n  = 3'd0;
            tx_n       = 1'b0;
            state_n    = START;
          end else begin
            bad_n = 1'b1;
          end
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          bit_idx_n  = 3'd0;
          tx_n       = cur_byte[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_n    = ^cur_byte;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          tx_n       = 1'b1;
          state_n    = STOP;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (byte_idx == 3'd5) begin
            tx_n    = 1'b1;
            sent_n  = 1'b1;
            state_n = IDLE;
          end else begin
            byte_idx_n = byte_idx + 3'd1;
            tx_n       = 1'b0;
            state_n    = START;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        state_n    = IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state != IDLE);
  assign sent     = sent_q;
  assign bad_code = bad_q;

endmodule

// File: tb/tb_color_msg_uart_tx.sv
// tb/tb_color_msg_uart_tx.sv - scoreboard bench for color_msg_uart_tx
module tb_color_msg_uart_tx;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int PKT    = FRAME * 6 * CPB;
  localparam int BUDGET = 2 * PKT;

  logic       clk50 = 1'b0;
  logic       rst_n;
  logic       done;
  logic [7:0] message;
  logic       tx, busy, sent, bad_code;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         bad_exp_q[$];

  color_msg_uart_tx #(.CLK_FREQ(1600000), .BAUD(100000)) dut (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .done    (done),
    .message (message),
    .tx      (tx),
    .busy    (busy),
    .sent    (sent),
    .bad_code(bad_code)
  );

  always #5 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // UART decoder and packet scoreboard
  int         dstate = 0;
  int         dcnt   = 0;
  logic [7:0] shreg;
  logic [7:0] rx_bytes[$];
  logic       prev_busy = 1'b0;
  bit         pkt_active = 0;
  int         t0 = 0;

  always @(negedge clk50) begin
    if (rst_n !== 1'b1) begin
      dstate     = 0;
      rx_bytes   = {};
      pkt_active = 0;
      prev_busy  = 1'b0;
    end else begin
      if (dstate == 0) begin
        if (tx == 1'b0) begin
          dstate = 1;
          dcnt   = 0;
        end
      end else begin
        dcnt++;
        if (dcnt % CPB == CPB / 2) begin
          int k;
          k = dcnt / CPB;
          if (k == 0) begin
            check(tx == 1'b0, "start_bit", tx, 0);
          end else if (k <= 8) begin
            shreg[k-1] = tx;
          end else if (k == FRAME - 1) begin
            check(tx == 1'b1, "stop_bit", tx, 1);
            rx_bytes.push_back(shreg);
            dstate = 0;
            if (rx_bytes.size() == 6) begin
              if (exp_q.size() == 0) begin
                check(0, "unexpected_packet", rx_bytes[3], 0);
              end else begin
                logic [7:0] m;
                logic [7:0] ref_b[6];
                m = exp_q.pop_front();
                ref_b = '{8'h53, 8'h49, 8'h2D, m, 8'h2D, 8'h23};
                for (int i = 0; i < 6; i++)
                  check(rx_bytes[i] == ref_b[i], $sformatf("byte%0d", i), rx_bytes[i], ref_b[i]);
              end
              rx_bytes = {};
            end
          end else begin
            check(tx == ^shreg, "parity_bit", tx, ^shreg);
          end
        end
      end

      if (busy && !prev_busy) begin
        t0         = cyc;
        pkt_active = 1;
        check(tx == 1'b0, "tx_low_at_busy_rise", tx, 0);
      end
      if (sent) begin
        check(pkt_active && !busy, "sent_with_busy_fall", busy, 0);
        check(cyc - t0 == PKT, "packet_length", cyc - t0, PKT);
        pkt_active = 0;
      end
      if (!busy && prev_busy)
        check(sent == 1'b1, "sent_at_busy_fall", sent, 1);
      if (bad_code) begin
        if (bad_exp_q.size() == 0) begin
          check(0, "unexpected_bad_code", 1, 0);
        end else begin
          void'(bad_exp_q.pop_front());
          check(!busy && tx, "bad_code_idle", {busy, tx}, 1);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk50);
      n++;
    end
    check(!busy, "busy_timeout", busy, 0);
    repeat (4) @(negedge clk50);
  endtask

  task automatic trigger(input logic [7:0] code, input bit hold);
    @(negedge clk50);
    message = code;
    done    = 1'b1;
    @(negedge clk50);
    if (!hold) done = 1'b0;
  endtask

  task automatic quiet_window(input int n, input string name);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk50);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check(lows == 0, name, lows, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    done    = 1'b0;
    message = 8'h00;
    repeat (5) @(negedge clk50);
    check(tx == 1'b1 && busy == 1'b0 && sent == 1'b0 && bad_code == 1'b0,
          "reset_outputs", {tx, busy, sent, bad_code}, 4'b1000);
    #2 rst_n = 1'b1;
    quiet_window(1000, "idle_after_reset");

    // 'D': tx must fall on the trigger edge
    exp_q.push_back(8'h44);
    @(negedge clk50);
    message = 8'h44;
    done    = 1'b1;
    @(negedge clk50);
    check(tx == 1'b0 && busy == 1'b1, "start_latency", {tx, busy}, 2'b01);
    done = 1'b0;
    wait_idle();

    // 'M' with done held: one packet, then silence
    exp_q.push_back(8'h4D);
    trigger(8'h4D, 1);
    wait_idle();
    quiet_window(2 * PKT, "no_retransmit_while_held");
    done = 1'b0;
    repeat (10) @(negedge clk50);

    // 'W' then a second edge mid-packet with a changed message
    exp_q.push_back(8'h57);
    trigger(8'h57, 0);
    repeat (PKT / 3) @(negedge clk50);
    message = 8'h44;
    done    = 1'b1;
    @(negedge clk50);
    done = 1'b0;
    repeat (20) @(negedge clk50);
    message = 8'h41;
    wait_idle();
    quiet_window(2 * PKT, "no_queued_packet");

    // illegal code
    bad_exp_q.push_back(1);
    trigger(8'h41, 0);
    check(busy == 1'b0 && tx == 1'b1, "illegal_stays_idle", {busy, tx}, 2'b01);
    quiet_window(100, "illegal_no_packet");

    // reset mid-packet, then a fresh packet
    exp_q.push_back(8'h44);
    trigger(8'h44, 0);
    repeat (PKT * 9 / 16) @(negedge clk50);
    #2 rst_n = 1'b0;
    #1 check(tx == 1'b1 && busy == 1'b0 && sent == 1'b0, "reset_abort",
             {tx, busy, sent}, 3'b100);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk50);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk50);
    exp_q.push_back(8'h57);
    trigger(8'h57, 0);
    wait_idle();

    check(exp_q.size() == 0, "packets_outstanding", exp_q.size(), 0);
    check(bad_exp_q.size() == 0, "bad_code_outstanding", bad_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/color_msg_uart_tx.md
Name: color_msg_uart_tx

Overview:
- Downstream consumer of the colour-sensor stage. Takes the 8-bit ASCII colour code and `done` flag it produces, and sends one framed packet per detection over a UART TX line to the XBee link.
- Packet is 6 bytes: 'S','I','-',MSG,'-','#'.
- Sits between the colour classifier and the wireless module pin. Runs on the same 50 MHz clock.

Parameters:
- CLK_FREQ, 50000000: input clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 434 at defaults): clk50 cycles per serial bit.

Ports:
- clk50 input 1: system clock, all logic on its rising edge.
- rst_n input 1: asynchronous active-low reset.
- done input 1: detection-valid level from the colour stage. Synchronous to clk50.
- message input 8: ASCII colour code; valid while done=1. Legal codes are 8'h44 'D', 8'h4D 'M', 8'h57 'W'.
- tx output 1: UART serial out. Idles high.
- busy output 1: high from packet start until the stop bit of byte 5 completes.
- sent output 1: one-cycle pulse when a packet finishes.
- bad_code output 1: one-cycle pulse when a done rising edge carries an illegal code.

Behaviour:
Reset (async, rst_n=0):
- Outputs: tx=1, busy=0, sent=0, bad_code=0.
- Internal: FSM=IDLE, all counters 0, done_q=0, captured message=8'h00.
- Reset mid-packet aborts the packet immediately. tx returns high asynchronously. No sent pulse.

Edge detect:
- done_q registers done every cycle. A trigger is done=1 && done_q=0, sampled at a clk50 edge.
- Trigger in IDLE with a legal code:
  - message is captured on that edge.
  - FSM goes to START; tx=0 and busy=1 from that same edge (latency 1 edge).
- Trigger in IDLE with an illegal code: bad_code pulses 1 cycle, FSM stays IDLE, tx stays 1.
- Trigger while busy: ignored entirely. No queueing, no bad_code.
- done held high after a packet completes: no retransmit; a new packet needs done to fall then rise.
- A done pulse of a single cycle is a valid trigger.

FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a legal trigger.
- START: tx=0 for CLKS_PER_BIT cycles, then -> DATA with bit_idx=0.
- DATA: tx=byte[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx<5: byte_idx+1, -> START. No inter-byte gap.
  - If byte_idx==5: -> IDLE. busy=0 and sent=1 on the same edge.

Counters:
- Baud counter is ceil(log2(CLKS_PER_BIT)) bits wide. Counts 0..CLKS_PER_BIT-1, resets to 0 on every bit boundary. Never free-runs in IDLE.
- bit_idx is 3 bits; byte_idx is 3 bits.

Timing and data rules:
- Byte mux is combinational from byte_idx: 0:'S' 8'h53, 1:'I' 8'h49, 2:'-' 8'h2D, 3:captured MSG, 4:'-' 8'h2D, 5:'#' 8'h23.
- Packet duration: exactly 60*CLKS_PER_BIT cycles (26040 at defaults) from the tx falling edge to busy falling.
- Captured MSG is stable for the whole packet. Changes on message mid-packet have no effect.
- tx is driven from a flop (glitch-free).

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits; packet is 66*CLKS_PER_BIT cycles (28644 at defaults).
- Undefined: 8N1 framing, 10-bit frames, no PARITY state.

Test Plan:
- Reset, rst_n held low 5 cycles, then released: tx=1, busy=0, sent=0, bad_code=0; tx stays 1 for 1000 cycles with done=0.
- done 0->1 with message=8'h44: tx falls on the trigger edge. Decoded bytes are 53 49 2D 44 2D 23, each bit 434 cycles. sent pulses once at cycle 26040 with busy falling the same edge.
- message=8'h4D, done held high 60000 cycles: exactly one packet with byte3=4D, then tx=1 for the remainder.
- message=8'h57, done pulsed; second done rising edge at cycle 10000 with 8'h44 and message changed mid-packet: one packet only, byte3=57, no bad_code.
- done rising with message=8'h41: bad_code pulses 1 cycle, busy stays 0, tx stays 1.
- rst_n asserted at cycle 15000 of a packet: tx=1 and busy=0 immediately, no sent pulse. A fresh done edge after release starts a complete new packet.
- UART_PARITY_EN defined, message=8'h44: parity bit per byte is 0 for 'S' (8'h53) and 1 for '#' (8'h23); packet length 28644 cycles.
